pe_load_sequencer: RTL and testbench
====================================

// Module: pe_load_sequencer
// PURPOSE
//  Sequences one PE pass: streams filter words from a 1-cycle-latency source memory into the PE
//  filter port, raises filter_done, waits GAP_CYCLES, raises start and streams ifmap rows
//  (ifmap_num x ifmap_size words). Honours PE ready backpressure on both ports.
//  Sits between the global buffer and a single PE; replaces bench-driven loading.
// PARAMETERS
//  DATA_WIDTH   16  word width of filter/ifmap data
//  ADDR_WIDTH   8   source memory address width
//  SIZE_WIDTH   5   width of filter_size / ifmap_size / ifmap_num config fields
//  GAP_CYCLES   2   idle cycles between filter_done rising and start rising (>=1)
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst            in   1           synchronous active-high reset
//  cfg_go         in   1           pulse: latch cfg_* and begin a pass (ignored unless IDLE)
//  cfg_abort      in   1           return to IDLE next cycle, outputs to reset values
//  cfg_filter_size / cfg_ifmap_size / cfg_ifmap_num  in  SIZE_WIDTH  word counts
//  cfg_filter_base / cfg_ifmap_base  in  ADDR_WIDTH  start addresses in source memory
//  mem_ren        out  1           read strobe; data valid on mem_rdata next cycle
//  mem_addr       out  ADDR_WIDTH  read address
//  mem_rdata      in   DATA_WIDTH  read data
//  pe_en          out  1           PE enable, high in every non-IDLE state
//  filter_wen / filter_din  out  1 / DATA_WIDTH  filter write to PE
//  filter_ready   in   1           PE filter buffer can accept
//  filter_done    out  1           all filter words delivered
//  start          out  1           ifmap streaming phase active
//  ifmap_wen / ifmap_din  out  1 / DATA_WIDTH  ifmap write to PE
//  ifmap_ready    in   1           PE ifmap buffer can accept
//  busy           out  1           not IDLE
//  done           out  1           one-cycle pulse at pass end
//  err            out  1           one-cycle pulse: zero-size config rejected
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-pass abandons it; no done pulse.
//  Handshake: a word is transferred on a posedge where wen && ready; wen/din stay stable until then.
//  FSM: IDLE -> F_RD -> F_WR -> (F_RD | F_FIN) -> GAP -> I_RD -> I_WR -> (I_RD | I_FIN) -> IDLE.
//   IDLE: cfg_go with any cfg size == 0 -> err pulse, stay IDLE; else latch cfg, go F_RD.
//   F_RD: mem_ren=1, mem_addr=filter_base+fcnt; next F_WR, capture mem_rdata into hold reg.
//   F_WR: filter_wen=1, filter_din=hold; on filter_ready fcnt++; last word -> F_FIN else F_RD.
//   F_FIN: filter_done<=1 (held until next cfg_go or rst/abort); GAP for GAP_CYCLES cycles.
//   GAP exit: start<=1 (held through last ifmap transfer), go I_RD.
//   I_RD/I_WR: as F_*, addr=ifmap_base+icnt, total = ifmap_size*ifmap_num words.
//   I_FIN: start<=0, done pulse, IDLE. pe_en falls with return to IDLE.
//  Throughput: 2 cycles/word when ready stays high (no prefetch); latency cfg_go -> first
//  filter_wen = 2 cycles.
//  Address arithmetic wraps modulo 2^ADDR_WIDTH; no error on wrap.
//  Total ifmap count computed in 2*SIZE_WIDTH bits; no truncation.
//  cfg_abort has priority over all transitions; cfg_go while busy ignored.
//  cfg_abort and cfg_go in same IDLE cycle: abort wins, go ignored.
// CONFIGURATION
//  PE_SEQ_PERF_EN defined: adds output stall_cnt [15:0] counting cycles with wen && !ready;
//   cleared on cfg_go, saturates at 16'hFFFF, held after done.
//  Undefined: no stall_cnt port, no counter logic.
// STRUCTURE
//  pe_seq_pkg: state enum typedef, GAP default, SIZE/ADDR width localparams.
//  One sub-module pe_seq_xfer: rd/hold/wr word mover (ren, addr, hold reg, wen/ready),
//   instanced once and shared by filter and ifmap phases.
// TESTING
//  1 filter_size=4, ifmap 8x3, ready always 1 -> 4 filter writes, filter_done, start after 2 cyc,
//    24 ifmap writes in memory order, done pulse, total 2+8+1+2+48+1 cycles approx.
//  2 filter_ready low 5 cycles on word 2 -> filter_wen held, filter_din unchanged, no word dropped.
//  3 cfg_ifmap_num=0 with cfg_go -> err pulse, busy stays 0, no mem_ren.
//  4 cfg_abort during I_WR word 10 -> next cycle all outputs 0, IDLE; new cfg_go runs clean pass.
//  5 cfg_ifmap_base=8'hFE, 4 words -> addresses FE,FF,00,01.
//  6 PE_SEQ_PERF_EN, ifmap_ready low 3 cycles twice -> stall_cnt=6 after done.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg
//   Shared definitions for the PE load sequencer: the sequencer state
//   encoding, default widths and the default filter/ifmap gap length.
package pe_seq_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int SIZE_WIDTH_DEF = 5;
  localparam int GAP_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F_RD,
    ST_F_WR,
    ST_F_FIN,
    ST_GAP,
    ST_I_RD,
    ST_I_WR,
    ST_I_FIN
  } state_t;

  // True in the states that belong to the ifmap streaming phase.
  function automatic logic is_ifmap_state(input state_t s);
    return (s == ST_I_RD) || (s == ST_I_WR);
  endfunction

endpackage

// File: rtl/pe_seq_xfer.sv
// pe_seq_xfer
//   Read / hold / write word mover shared by the filter and ifmap phases.
//   A read is issued in the RD state; the word arrives on i_rdata one cycle
//   later, during the WR state. If the PE is not ready in that first WR
//   cycle the word is parked in a hold register so o_din stays stable while
//   the source memory output is free to change.
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rd, i_wr          current state is a read / write state
//   i_base, i_off       word address = base + offset (wraps)
//   i_ready             PE port ready for the active phase
//   i_rdata             source memory read data
//   o_ren, o_addr       source memory read strobe and address
//   o_wen, o_din        write strobe and data towards the PE
//   o_xfer              a word is accepted on the coming edge
module pe_seq_xfer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_off,
  input  logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_ren,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_wen,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic                  o_xfer
);

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_vld;

  // The hold register is loaded in the first WR cycle only; r_hold_vld
  // stays set for as long as the write is still waiting for ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      if (i_wr && !r_hold_vld) begin
        r_hold <= i_rdata;
      end
      r_hold_vld <= i_wr && !i_ready;
    end
  end

  assign o_ren  = i_rd;
  assign o_addr = i_rd ? (i_base + i_off) : '0;
  assign o_wen  = i_wr;
  assign o_din  = i_wr ? (r_hold_vld ? r_hold : i_rdata) : '0;
  assign o_xfer = i_wr && i_ready;

endmodule

// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer
//   Sequences one PE pass: streams filter words from a 1-cycle-latency
//   source memory into the PE filter port, raises filter_done, waits
//   GAP_CYCLES, raises start and streams ifmap_size*ifmap_num ifmap words.
//   Both PE ports are flow-controlled with wen/ready.
// Optional feature
//   PE_SEQ_PERF_EN : adds o_stall_cnt, a saturating count of cycles in which
//                    a write is offered but the PE is not ready.
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_cfg_go, i_cfg_abort             start a pass / abandon it
//   i_cfg_filter_size, i_cfg_ifmap_size, i_cfg_ifmap_num   word counts
//   i_cfg_filter_base, i_cfg_ifmap_base                    start addresses
//   o_mem_ren, o_mem_addr, i_mem_rdata                     source memory
//   o_pe_en                           PE enable (not IDLE)
//   o_filter_wen, o_filter_din, i_filter_ready, o_filter_done
//   o_start, o_ifmap_wen, o_ifmap_din, i_ifmap_ready
//   o_busy, o_done, o_err             status / one-cycle pulses
//   o_stall_cnt                       (PE_SEQ_PERF_EN only)
module pe_load_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_go,
  input  logic                  i_cfg_abort,
  input  logic [SIZE_WIDTH-1:0] i_cfg_filter_size,
  input  logic [SIZE_WIDTH-1:0] i_cfg_ifmap_size,
  input  logic [SIZE_WIDTH-1:0] i_cfg_ifmap_num,
  input  logic [ADDR_WIDTH-1:0] i_cfg_filter_base,
  input  logic [ADDR_WIDTH-1:0] i_cfg_ifmap_base,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_pe_en,
  output logic                  o_filter_wen,
  output logic [DATA_WIDTH-1:0] o_filter_din,
  input  logic                  i_filter_ready,
  output logic                  o_filter_done,
  output logic                  o_start,
  output logic                  o_ifmap_wen,
  output logic [DATA_WIDTH-1:0] o_ifmap_din,
  input  logic                  i_ifmap_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [15:0]           o_stall_cnt
`endif
);

  // Word counter is wide enough for ifmap_size*ifmap_num without truncation.
  localparam int CW = 2 * SIZE_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_f_total;
  logic [CW-1:0]         r_i_total;
  logic [ADDR_WIDTH-1:0] r_f_base;
  logic [ADDR_WIDTH-1:0] r_i_base;
  logic                  r_filter_done;
  logic                  r_start;
  logic                  r_err;

  logic                  w_cfg_zero;
  logic                  w_go_idle;
  logic                  w_go_ok;
  logic                  w_phase_i;
  logic [CW-1:0]         w_total;
  logic                  w_last;
  logic                  w_gap_last;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_ready;
  logic                  w_wen;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_din;

  assign w_cfg_zero = (i_cfg_filter_size == '0) || (i_cfg_ifmap_size == '0) ||
                      (i_cfg_ifmap_num == '0);
  assign w_go_idle  = (r_state == ST_IDLE) && i_cfg_go && !i_cfg_abort;
  assign w_go_ok    = w_go_idle && !w_cfg_zero;

  assign w_phase_i  = is_ifmap_state(r_state);
  assign w_total    = w_phase_i ? r_i_total : r_f_total;
  assign w_last     = (r_cnt == (w_total - CW'(1)));
  // During GAP the word counter is reused as the gap timer.
  assign w_gap_last = (r_cnt == CW'(GAP_CYCLES - 1));

  assign w_rd    = (r_state == ST_F_RD) || (r_state == ST_I_RD);
  assign w_wr    = (r_state == ST_F_WR) || (r_state == ST_I_WR);
  assign w_ready = w_phase_i ? i_ifmap_ready : i_filter_ready;

  pe_seq_xfer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_xfer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rd    (w_rd),
    .i_wr    (w_wr),
    .i_base  (w_phase_i ? r_i_base : r_f_base),
    .i_off   (ADDR_WIDTH'(r_cnt)),
    .i_ready (w_ready),
    .i_rdata (i_mem_rdata),
    .o_ren   (o_mem_ren),
    .o_addr  (o_mem_addr),
    .o_wen   (w_wen),
    .o_din   (w_din),
    .o_xfer  (w_xfer)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_go_ok) w_state_next = ST_F_RD;
      ST_F_RD:  w_state_next = ST_F_WR;
      ST_F_WR:  if (w_xfer) w_state_next = w_last ? ST_F_FIN : ST_F_RD;
      ST_F_FIN: w_state_next = ST_GAP;
      ST_GAP:   if (w_gap_last) w_state_next = ST_I_RD;
      ST_I_RD:  w_state_next = ST_I_WR;
      ST_I_WR:  if (w_xfer) w_state_next = w_last ? ST_I_FIN : ST_I_RD;
      ST_I_FIN: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (i_cfg_abort) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_f_total     <= '0;
      r_i_total     <= '0;
      r_f_base      <= '0;
      r_i_base      <= '0;
      r_filter_done <= 1'b0;
      r_start       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (i_cfg_abort) begin
        r_cnt         <= '0;
        r_filter_done <= 1'b0;
        r_start       <= 1'b0;
        r_err         <= 1'b0;
      end else begin
        r_err <= w_go_idle && w_cfg_zero;
        if (w_go_idle) begin
          r_filter_done <= 1'b0;
        end
        if (w_go_ok) begin
          r_cnt     <= '0;
          r_f_total <= CW'(i_cfg_filter_size);
          r_i_total <= CW'(i_cfg_ifmap_size) * CW'(i_cfg_ifmap_num);
          r_f_base  <= i_cfg_filter_base;
          r_i_base  <= i_cfg_ifmap_base;
        end
        if (w_xfer) begin
          r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
        end
        if (r_state == ST_F_FIN) begin
          r_filter_done <= 1'b1;
        end
        if (r_state == ST_GAP) begin
          r_cnt <= w_gap_last ? '0 : (r_cnt + CW'(1));
          if (w_gap_last) begin
            r_start <= 1'b1;
          end
        end
        // start drops on the edge that accepts the final ifmap word.
        if ((r_state == ST_I_WR) && w_xfer && w_last) begin
          r_start <= 1'b0;
        end
      end
    end
  end

`ifdef PE_SEQ_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cfg_abort) begin
      r_stall_cnt <= '0;
    end else if (w_go_idle) begin
      r_stall_cnt <= '0;
    end else if (w_wen && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_busy        = (r_state != ST_IDLE);
  assign o_pe_en       = o_busy;
  assign o_done        = (r_state == ST_I_FIN);
  assign o_err         = r_err;
  assign o_filter_done = r_filter_done;
  assign o_start       = r_start;
  assign o_filter_wen  = w_wen && !w_phase_i;
  assign o_filter_din  = w_phase_i ? '0 : w_din;
  assign o_ifmap_wen   = w_wen && w_phase_i;
  assign o_ifmap_din   = w_phase_i ? w_din : '0;

endmodule

// File: tb/tb_pe_load_sequencer.sv
// tb_pe_load_sequencer
//   Directed and randomized passes against a behavioural model: expected
//   word streams come straight from the source memory image, expected timing
//   from the cycle budget of a pass (2 cycles per word, 1 finish cycle per
//   phase, GAP idle cycles, plus one cycle per stalled write).
module tb_pe_load_sequencer;

  localparam int GAP   = 2;
  localparam int LIMIT = 6000;

  logic        clk;
  logic        rst;
  logic        cfg_go;
  logic        cfg_abort;
  logic [4:0]  cfg_filter_size;
  logic [4:0]  cfg_ifmap_size;
  logic [4:0]  cfg_ifmap_num;
  logic [7:0]  cfg_filter_base;
  logic [7:0]  cfg_ifmap_base;
  logic        mem_ren;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        pe_en;
  logic        filter_wen;
  logic [15:0] filter_din;
  logic        filter_ready;
  logic        filter_done;
  logic        start;
  logic        ifmap_wen;
  logic [15:0] ifmap_din;
  logic        ifmap_ready;
  logic        busy;
  logic        done;
  logic        err;
`ifdef PE_SEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  logic [15:0] mem [256];
  int checks;
  int errors;

  pe_load_sequencer #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (8),
    .SIZE_WIDTH (5),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cfg_go          (cfg_go),
    .i_cfg_abort       (cfg_abort),
    .i_cfg_filter_size (cfg_filter_size),
    .i_cfg_ifmap_size  (cfg_ifmap_size),
    .i_cfg_ifmap_num   (cfg_ifmap_num),
    .i_cfg_filter_base (cfg_filter_base),
    .i_cfg_ifmap_base  (cfg_ifmap_base),
    .o_mem_ren         (mem_ren),
    .o_mem_addr        (mem_addr),
    .i_mem_rdata       (mem_rdata),
    .o_pe_en           (pe_en),
    .o_filter_wen      (filter_wen),
    .o_filter_din      (filter_din),
    .i_filter_ready    (filter_ready),
    .o_filter_done     (filter_done),
    .o_start           (start),
    .o_ifmap_wen       (ifmap_wen),
    .o_ifmap_din       (ifmap_din),
    .i_ifmap_ready     (ifmap_ready),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err)
`ifdef PE_SEQ_PERF_EN
    ,
    .o_stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: 1-cycle read latency; output is scrambled when not read
  // so a missing hold register shows up as corrupted data.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
    else         mem_rdata <= 16'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int f, input int isz, input int inum,
                          input logic [7:0] fb, input logic [7:0] ib,
                          input int rdy_pct, input int fsw, input int fsl,
                          input int isw, input int isl, input int abort_w);
    logic [15:0] exp_f[$];
    logic [15:0] exp_i[$];
    logic [7:0]  a;
    logic [15:0] p_fdin, p_idin;
    int n, fk, ik, cyc, stalls, fd_cyc, st_cyc, first_wen, done_cyc, f_left, i_left;
    bit aborted, p_fst, p_ist;
    n = isz * inum;
    for (int k = 0; k < f; k++) begin a = fb + 8'(k); exp_f.push_back(mem[a]); end
    for (int k = 0; k < n; k++) begin a = ib + 8'(k); exp_i.push_back(mem[a]); end
    fk = 0; ik = 0; stalls = 0; fd_cyc = -1; st_cyc = -1; first_wen = -1; done_cyc = -1;
    f_left = fsl; i_left = isl; aborted = 0; p_fst = 0; p_ist = 0; p_fdin = '0; p_idin = '0;

    cfg_filter_size = 5'(f);
    cfg_ifmap_size  = 5'(isz);
    cfg_ifmap_num   = 5'(inum);
    cfg_filter_base = fb;
    cfg_ifmap_base  = ib;
    cfg_go          = 1'b1;
    tick();
    // Scramble the config so a design that re-reads it mid-pass is caught.
    cfg_filter_size = 5'($urandom);
    cfg_ifmap_size  = 5'($urandom);
    cfg_ifmap_num   = 5'($urandom);
    cfg_filter_base = 8'($urandom);
    cfg_ifmap_base  = 8'($urandom);
    cyc = 1;
    while (cyc < LIMIT && done_cyc < 0 && !aborted) begin
      cfg_go       = (cyc == 5);  // must be ignored while busy
      filter_ready = ($urandom_range(99) < rdy_pct);
      ifmap_ready  = ($urandom_range(99) < rdy_pct);
      if (filter_wen && fk == fsw && f_left > 0) begin filter_ready = 1'b0; f_left--; end
      if (ifmap_wen && ik == isw && i_left > 0) begin ifmap_ready = 1'b0; i_left--; end
      if (ifmap_wen && ik == abort_w) begin cfg_abort = 1'b1; ifmap_ready = 1'b0; end
      #1;
      chk("busy", busy, 1'b1);
      chk("pe_en", pe_en, 1'b1);
      chk("err_quiet", err, 1'b0);
      chk("one_wen", filter_wen && ifmap_wen, 1'b0);
      if (mem_ren) begin
        a = (fk < f) ? fb + 8'(fk) : ib + 8'(ik);
        chk("mem_addr", mem_addr, a);
      end
      if (filter_wen) begin
        if (first_wen < 0) first_wen = cyc;
        if (p_fst) chk("f_din_hold", filter_din, p_fdin);
        if (filter_ready) begin
          chk("f_in_range", fk < f, 1'b1);
          if (fk < f) chk("f_data", filter_din, exp_f[fk]);
          fk++;
        end else begin
          stalls++;
        end
        p_fst  = !filter_ready;
        p_fdin = filter_din;
      end else begin
        p_fst = 1'b0;
      end
      if (ifmap_wen) begin
        chk("start_during_ifmap", start, 1'b1);
        if (p_ist) chk("i_din_hold", ifmap_din, p_idin);
        if (ifmap_ready) begin
          chk("i_in_range", ik < n, 1'b1);
          if (ik < n) chk("i_data", ifmap_din, exp_i[ik]);
          ik++;
        end else if (!cfg_abort) begin
          stalls++;
        end
        p_ist  = !ifmap_ready;
        p_idin = ifmap_din;
      end else begin
        p_ist = 1'b0;
      end
      if (filter_done && fd_cyc < 0) fd_cyc = cyc;
      if (start && st_cyc < 0) begin
        st_cyc = cyc;
        chk("filter_before_start", fk, f);
      end
      if (done) begin
        done_cyc = cyc;
        chk("start_low_at_done", start, 1'b0);
        chk("fdone_at_done", filter_done, 1'b1);
      end
      if (cfg_abort) aborted = 1;
      tick();
      cyc++;
    end
    cfg_go = 1'b0;

    if (abort_w >= 0) begin
      cfg_abort = 1'b0;
      chk("abort_seen", aborted, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_pe_en", pe_en, 1'b0);
      chk("abort_fdone", filter_done, 1'b0);
      chk("abort_start", start, 1'b0);
      chk("abort_iwen", ifmap_wen, 1'b0);
      chk("abort_ren", mem_ren, 1'b0);
      chk("abort_done", done, 1'b0);
    end else begin
      chk("done_seen", done_cyc >= 0, 1'b1);
      chk("f_count", fk, f);
      chk("i_count", ik, n);
      chk("first_wen_lat", first_wen, 2);
      chk("gap_len", st_cyc - fd_cyc, GAP);
      chk("pass_cycles", done_cyc, 2 * f + 2 * n + GAP + 2 + stalls);
      chk("done_pulse", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("fdone_held", filter_done, 1'b1);
      chk("start_idle", start, 1'b0);
`ifdef PE_SEQ_PERF_EN
      chk("stall_cnt", stall_cnt, stalls);
`endif
    end
    $display("pass f=%0d ifmap=%0dx%0d fb=%02h ib=%02h stalls=%0d cycles=%0d abort=%0d",
             f, isz, inum, fb, ib, stalls, done_cyc, aborted);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1'b1; cfg_go = 1'b0; cfg_abort = 1'b0;
    cfg_filter_size = '0; cfg_ifmap_size = '0; cfg_ifmap_num = '0;
    cfg_filter_base = '0; cfg_ifmap_base = '0;
    filter_ready = 1'b1; ifmap_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_pe_en", pe_en, 1'b0);
    chk("rst_ren", mem_ren, 1'b0);
    chk("rst_fwen", filter_wen, 1'b0);
    chk("rst_iwen", ifmap_wen, 1'b0);
    chk("rst_fdone", filter_done, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Baseline pass, ready always high.
    run_pass(4, 8, 3, 8'h10, 8'h40, 100, -1, 0, -1, 0, -1);
    // Filter stalled 5 cycles on word 2.
    run_pass(4, 3, 2, 8'h20, 8'h80, 100, 2, 5, -1, 0, -1);

    // Zero-size configurations are rejected with an err pulse.
    cfg_filter_size = 5'd3; cfg_ifmap_size = 5'd2; cfg_ifmap_num = 5'd0; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("zero_num_err", err, 1'b1);
    chk("zero_num_busy", busy, 1'b0);
    chk("zero_num_ren", mem_ren, 1'b0);
    tick();
    chk("zero_err_pulse", err, 1'b0);
    chk("zero_busy_after", busy, 1'b0);
    cfg_filter_size = 5'd0; cfg_ifmap_num = 5'd2; cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("zero_fsize_err", err, 1'b1);
    chk("zero_fsize_busy", busy, 1'b0);
    tick();

    // Abort and go in the same idle cycle: abort wins.
    cfg_filter_size = 5'd2; cfg_ifmap_size = 5'd2; cfg_ifmap_num = 5'd2;
    cfg_go = 1'b1; cfg_abort = 1'b1;
    tick();
    cfg_go = 1'b0; cfg_abort = 1'b0;
    chk("go_abort_busy", busy, 1'b0);
    chk("go_abort_err", err, 1'b0);
    tick();
    chk("go_abort_still_idle", busy, 1'b0);

    // Abort on ifmap word 10, then a clean pass.
    run_pass(3, 4, 4, 8'h30, 8'h50, 100, -1, 0, -1, 0, 10);
    run_pass(3, 4, 4, 8'h30, 8'h50, 100, -1, 0, -1, 0, -1);
    // Address wrap on both phases.
    run_pass(5, 2, 2, 8'hFD, 8'hFE, 100, -1, 0, -1, 0, -1);
    // Two stall windows of 3 cycles each.
    run_pass(2, 3, 2, 8'h00, 8'h60, 100, 1, 3, 2, 3, -1);
    // Smallest legal pass.
    run_pass(1, 1, 1, 8'h77, 8'h78, 100, -1, 0, -1, 0, -1);
    // Randomized passes with random backpressure.
    for (int r = 0; r < 4; r++) begin
      run_pass(int'($urandom_range(8, 1)), int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
               8'($urandom), 8'($urandom), int'($urandom_range(90, 50)), -1, 0, -1, 0, -1);
    end
    // Largest pass: 31x31 ifmap words needs the wide count.
    run_pass(31, 31, 31, 8'hC0, 8'h05, 100, -1, 0, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
